// File: rtl/tick_scheduler_if.sv
// Configuration and tick-output bundle for tick_scheduler.
// The master writes channel configuration and observes the ticks. The slave is the scheduler.
interface tick_scheduler_if #(
  parameter int NCH = 4,
  parameter int PW  = 16
);
  logic           cfg_we;
  logic [2:0]     cfg_ch;
  logic [PW-1:0]  cfg_period;
  logic           cfg_oneshot;
  logic           cfg_en;
  logic           base_tick;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] active;

  modport master (
    output cfg_we, cfg_ch, cfg_period, cfg_oneshot, cfg_en,
    input  base_tick, tick, active
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_period, cfg_oneshot, cfg_en,
    output base_tick, tick, active
  );
endinterface

// File: rtl/tick_scheduler.sv
// Shared timebase: one free-running prescaler produces a base tick.
// NCH channels divide that base tick into one-cycle clock-enable pulses.
module tick_scheduler #(
  parameter int CLK_FREQ  = 100000000,
  parameter int TICK_FREQ = 1000,
  parameter int NCH       = 4,
  parameter int PW        = 16
) (
  input  logic              clk,
  input  logic              rst,
  tick_scheduler_if.slave   bus
);
  localparam int DIV = CLK_FREQ / TICK_FREQ;
  localparam int PSW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PSW-1:0] PRESC_LAST = PSW'(DIV - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  logic [PSW-1:0] presc_reg;
  logic [PSW-1:0] presc_next;
  logic           base;
  logic [NCH-1:0] tick_vec;
  logic [NCH-1:0] active_vec;

  // Gating with rst keeps base_tick low while reset is held, even when DIV=1.
  assign base = (presc_reg == PRESC_LAST) && !rst;

  always_comb begin
    presc_next = presc_reg + PSW'(1);
    if (presc_reg == PRESC_LAST) begin
      presc_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      state_t        state_reg, state_next;
      logic [PW-1:0] cnt_reg, cnt_next;
      logic [PW-1:0] period_reg, period_next;
      logic          oneshot_reg, oneshot_next;
      logic          tick_reg, tick_next;
      logic          wr;

      assign wr = bus.cfg_we && (bus.cfg_ch == 3'(gi));

      // A write to this channel overrides any expiry in the same cycle.
      always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        period_next  = period_reg;
        oneshot_next = oneshot_reg;
        tick_next    = 1'b0;
        if (wr) begin
          if (bus.cfg_en && (bus.cfg_period != '0)) begin
            period_next  = bus.cfg_period;
            oneshot_next = bus.cfg_oneshot;
            cnt_next     = bus.cfg_period;
            state_next   = RUN;
          end else begin
            cnt_next   = '0;
            state_next = IDLE;
          end
        end else begin
          case (state_reg)
            RUN: begin
              if (base) begin
                if (cnt_reg > PW'(1)) begin
                  cnt_next = cnt_reg - PW'(1);
                end else begin
                  tick_next = 1'b1;
                  if (oneshot_reg) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                  end else begin
                    cnt_next = period_reg;
                  end
                end
              end
            end
            default: begin
              state_next = IDLE;
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg   <= IDLE;
          cnt_reg     <= '0;
          period_reg  <= '0;
          oneshot_reg <= 1'b0;
          tick_reg    <= 1'b0;
        end else begin
          state_reg   <= state_next;
          cnt_reg     <= cnt_next;
          period_reg  <= period_next;
          oneshot_reg <= oneshot_next;
          tick_reg    <= tick_next;
        end
      end

      assign tick_vec[gi]   = tick_reg;
      assign active_vec[gi] = (state_reg == RUN);
    end
  endgenerate

  assign bus.base_tick = base;
  assign bus.tick      = tick_vec;
  assign bus.active    = active_vec;
endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler (DIV=4, NCH=4, PW=16).
// Expected tick cycles are predicted at each write and consumed as the DUT emits them.
module tb_tick_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  bit   started = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  logic [3:0] exp_tick [int];

  tick_scheduler_if #(.NCH(4), .PW(16)) bus ();

  tick_scheduler #(
    .CLK_FREQ(8), .TICK_FREQ(2), .NCH(4), .PW(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // cyc is the index of the current cycle since the last reset edge; the prescaler equals cyc%4.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s at cyc %0d: observed %0h expected %0h", name, cyc, obs, want);
    end
  endtask

  function automatic int next_base(input int c);
    int b;
    b = c + 1;
    while (b % 4 != 3) b++;
    return b;
  endfunction

  task automatic push_tick(input int t, input int ch);
    logic [3:0] m;
    m = exp_tick.exists(t) ? exp_tick[t] : 4'b0000;
    m[ch] = 1'b1;
    exp_tick[t] = m;
  endtask

  // Predict ticks of a write made in cycle c, up to (and including) cycle upto.
  task automatic predict(input int c, input int ch, input int per, input bit os, input int upto);
    int t;
    t = next_base(c) + 4 * (per - 1) + 1;
    if (os) begin
      push_tick(t, ch);
    end else begin
      while (t <= upto) begin
        push_tick(t, ch);
        t += 4 * per;
      end
    end
  endtask

  task automatic goto(input int target);
    int guard;
    guard = 0;
    while (cyc != target && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("goto_bound", cyc, target);
  endtask

  // Called at #1 into the write cycle; returns at #1 into the following cycle.
  task automatic do_write(input int ch, input int per, input bit os, input bit en, input int upto);
    $display("write cyc=%0d ch=%0d period=%0d oneshot=%0d en=%0d", cyc, ch, per, os, en);
    bus.cfg_we      = 1'b1;
    bus.cfg_ch      = 3'(ch);
    bus.cfg_period  = 16'(per);
    bus.cfg_oneshot = os;
    bus.cfg_en      = en;
    if (en && per != 0 && ch < 4) predict(cyc, ch, per, os, upto);
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [3:0] want;
    if (started) begin
      check("base_tick", 32'(bus.base_tick), 32'(!rst && (cyc % 4 == 3)));
      if (bus.tick != 4'b0000 || exp_tick.exists(cyc)) begin
        want = exp_tick.exists(cyc) ? exp_tick[cyc] : 4'b0000;
        $display("tick cyc=%0d observed=%b expected=%b", cyc, bus.tick, want);
        check("tick", 32'(bus.tick), 32'(want));
        exp_tick.delete(cyc);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_we      = 1'b0;
    bus.cfg_ch      = 3'd0;
    bus.cfg_period  = 16'd0;
    bus.cfg_oneshot = 1'b0;
    bus.cfg_en      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;
    check("reset_tick", 32'(bus.tick), 32'h0);
    check("reset_active", 32'(bus.active), 32'h0);
    check("reset_base", 32'(bus.base_tick), 32'h0);

    goto(12);
    do_write(0, 3, 1'b0, 1'b1, 48);       // ticks 24, 36, 48
    check("active_ch0_on", 32'(bus.active), 32'h1);

    goto(14);
    do_write(1, 2, 1'b1, 1'b1, 0);        // single tick at 20
    check("active_ch1_on", 32'(bus.active), 32'h3);

    goto(21);
    check("active_ch1_done", 32'(bus.active), 32'h1);

    goto(25);
    do_write(2, 1, 1'b0, 1'b1, 85);
    do_write(3, 1, 1'b0, 1'b1, 91);
    check("active_all_period1", 32'(bus.active), 32'hD);

    goto(59);                              // ch0 cnt==1 expiry cycle
    do_write(0, 5, 1'b0, 1'b1, 90);       // tick at 60 suppressed, next at 80
    check("active_after_rewrite", 32'(bus.active), 32'hD);

    goto(85);
    do_write(2, 0, 1'b0, 1'b1, 0);        // period 0 stops ch2
    check("active_ch2_off", 32'(bus.active), 32'h9);

    goto(91);                              // base-tick cycle with ch3 about to expire
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_tick", 32'(bus.tick), 32'h0);
    check("midrst_active", 32'(bus.active), 32'h0);

    do_write(5, 1, 1'b0, 1'b1, 0);
    check("bad_ch5_active", 32'(bus.active), 32'h0);
    do_write(4, 2, 1'b0, 1'b1, 0);
    check("bad_ch4_active", 32'(bus.active), 32'h0);
    repeat (12) @(posedge clk);
    #1;
    check("bad_ch_still_idle", 32'(bus.active), 32'h0);
    check("scoreboard_empty", 32'(exp_tick.num()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
